// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle execute-stage ALU.
// Opcode encodings, FSM states and NZCV bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_EOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Combinational A +/- B with carry-out and signed overflow.
// Subtraction is A + ~B + 1, so carry-out 1 means "no borrow".
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b     = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_carry = w_full[WIDTH];
  assign o_ovf   = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic ops, shift-and-add MUL
// one multiplier bit per cycle, behind a valid/ready handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_flags
);

  localparam int CW = $clog2(WIDTH);

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  alu_op_t          w_op;
  logic             w_mul_start;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic [CW-1:0]    w_bit_idx;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_write;
  logic [3:0]       w_flags;

  assign w_op      = alu_op_t'(alu_op);
  assign in_ready  = (r_state == IDLE);
  // Bit 0 is folded into the accept edge, so MUL cycles handle bits 1..WIDTH-1.
  assign w_bit_idx = r_cnt + CW'(1);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (w_add_a),
    .i_b     (w_add_b),
    .i_sub   (w_sub),
    .o_sum   (w_sum),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  // Next-state, shared adder operand steering and result/flag selection.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_add_a     = src_a;
    w_add_b     = src_b;
    w_sub       = 1'b0;
    w_acc_nxt   = r_acc;
    w_res       = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        w_sub = (w_op == OP_SUB);
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_res = w_sum;
            w_c   = w_carry;
            w_v   = w_ovf;
          end
          OP_AND:  w_res = src_a & src_b;
          OP_ORR:  w_res = src_a | src_b;
          OP_EOR:  w_res = src_a ^ src_b;
          default: w_res = '0;
        endcase
        if (in_valid && (w_op == OP_MUL)) begin
          w_mul_start = 1'b1;
          w_state_nxt = MUL;
        end else if (in_valid) begin
          w_write = 1'b1;
        end else begin
          w_write = 1'b0;
        end
      end
      MUL: begin
        w_add_a   = r_acc;
        w_add_b   = r_a << w_bit_idx;
        w_acc_nxt = r_b[w_bit_idx] ? w_sum : r_acc;
        if (r_cnt == CW'(WIDTH - 2)) begin
          w_res       = w_acc_nxt;
          w_write     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_res       = '0;
          w_write     = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Multiplier operands, accumulator, bit counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
    end else begin
      r_out_valid <= w_write;
      if (w_write) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
      if (w_mul_start) begin
        r_a   <= src_a;
        r_b   <= src_b;
        r_acc <= src_a & {WIDTH{src_b[0]}};
        r_cnt <= '0;
      end else if (r_state == MUL) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign alu_flags  = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32 and WIDTH=8.
// Inputs are driven 1ns after the rising edge and outputs sampled there.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v32, v8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        rdy32, rdy8, ov32, ov8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [3:0]  fl32, fl8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(rdy32),
    .src_a(a32), .src_b(b32), .alu_op(op32), .out_valid(ov32),
    .alu_result(res32), .alu_flags(fl32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
    .src_a(a8), .src_b(b8), .alu_op(op8), .out_valid(ov8),
    .alu_result(res8), .alu_flags(fl8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      v8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      v32 = v; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic check_out(input bit w8, input string tag, input logic [31:0] er,
                           input logic [3:0] ef);
    check({tag, ".valid"}, w8 ? 32'(ov8) : 32'(ov32), 32'd1);
    check({tag, ".res"}, w8 ? 32'(res8) : res32, er);
    check({tag, ".flags"}, w8 ? 32'(fl8) : 32'(fl32), 32'(ef));
  endtask

  // One simple op: accept on the next edge, result expected the cycle after.
  task automatic simple(input bit w8, input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
    check({tag, ".ready"}, w8 ? 32'(rdy8) : 32'(rdy32), 32'd1);
    drive(w8, 1'b1, op, a, b);
    step();
    drive(w8, 1'b0, 3'b000, 32'd0, 32'd0);
    check_out(w8, tag, er, ef);
    step();
    check({tag, ".pulse"}, w8 ? 32'(ov8) : 32'(ov32), 32'd0);
  endtask

  // MUL with in_valid held high (ADD) during the busy window to prove it is ignored.
  task automatic mul(input bit w8, input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                     input int n);
    drive(w8, 1'b1, 3'b101, a, b);
    step();
    drive(w8, 1'b1, 3'b000, 32'd1, 32'd1);
    for (int j = 1; j < n; j++) begin
      check({tag, ".busy_ready"}, w8 ? 32'(rdy8) : 32'(rdy32), 32'd0);
      check({tag, ".busy_valid"}, w8 ? 32'(ov8) : 32'(ov32), 32'd0);
      if (j == n - 1) drive(w8, 1'b0, 3'b000, 32'd0, 32'd0);
      step();
    end
    check_out(w8, tag, er, ef);
    check({tag, ".ready"}, w8 ? 32'(rdy8) : 32'(rdy32), 32'd1);
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 32'd1, 32'd1);
    drive(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
    step();
    check("rst1.valid", 32'(ov32), 32'd0);
    step();
    check("rst2.valid", 32'(ov32), 32'd0);
    check("rst2.res", res32, 32'd0);
    check("rst2.flags", 32'(fl32), 32'd0);
    check("rst8.res", 32'(res8), 32'd0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    check("rst.ready", 32'(rdy32), 32'd1);
    step();
    check("rst.after_valid", 32'(ov32), 32'd0);

    simple(1'b0, "add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    simple(1'b0, "add_carry", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
    simple(1'b0, "sub_eq", 3'b001, 32'd5, 32'd5, 32'h0, 4'b0110);
    simple(1'b0, "sub_neg", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000);
    simple(1'b0, "rsv6", 3'b110, 32'h1234, 32'h5678, 32'h0, 4'b0100);

    // Back-to-back logic ops on consecutive cycles.
    drive(1'b0, 1'b1, 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    step();
    drive(1'b0, 1'b1, 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_out(1'b0, "and", 32'h00F0_00F0, 4'b0000);
    step();
    drive(1'b0, 1'b1, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_out(1'b0, "orr", 32'hFFF0_FFF0, 4'b1000);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    check_out(1'b0, "eor", 32'hFF00_FF00, 4'b1000);
    step();
    check("logic.idle", 32'(ov32), 32'd0);
    check("logic.hold", res32, 32'hFF00_FF00);

    mul(1'b0, "mul32", 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 4'b0000, 32);
    mul(1'b0, "mul32_b0", 32'hDEAD_BEEF, 32'h0, 32'h0, 4'b0100, 32);

    // Reset during MUL: abort, no pulse, then normal latency resumes.
    drive(1'b0, 1'b1, 3'b101, 32'd3, 32'd5);
    step();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    for (int j = 1; j < 10; j++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort.ready", 32'(rdy32), 32'd1);
    check("abort.res", res32, 32'd0);
    for (int j = 0; j < 30; j++) begin
      check("abort.no_valid", 32'(ov32), 32'd0);
      step();
    end
    simple(1'b0, "add_after_abort", 3'b000, 32'd2, 32'd2, 32'd4, 4'b0000);

    simple(1'b1, "w8_add_ovf", 3'b000, 32'h7F, 32'h01, 32'h80, 4'b1001);
    simple(1'b1, "w8_add_carry", 3'b000, 32'hFF, 32'h01, 32'h00, 4'b0110);
    simple(1'b1, "w8_sub_eq", 3'b001, 32'h05, 32'h05, 32'h00, 4'b0110);
    simple(1'b1, "w8_sub_neg", 3'b001, 32'h03, 32'h05, 32'hFE, 4'b1000);
    simple(1'b1, "w8_sub_ovf", 3'b001, 32'h80, 32'h01, 32'h7F, 4'b0011);
    mul(1'b1, "w8_mul", 32'h13, 32'h0B, 32'hD1, 4'b1000, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle successor to the single-cycle datapath ALU. Executes ADD/SUB/AND/ORR/EOR in one registered cycle and an unsigned/low-half MUL iteratively (one bit per cycle) behind a valid/ready handshake. Sits in the execute stage; the control unit stalls on `in_ready` low. Produces ARM-style NZCV flags.

## Interface
- `WIDTH`, 32: operand/result width (≥4).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept; transfer when `in_valid && in_ready`.
- `src_a`  in  WIDTH  operand A.
- `src_b`  in  WIDTH  operand B.
- `alu_op`  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110/111 reserved.
- `out_valid`  out  1  one-cycle pulse: `alu_result`/`alu_flags` updated.
- `alu_result`  out  WIDTH  registered result, held until next `out_valid`.
- `alu_flags`  out  4  registered {N,Z,C,V} = bits [3:0], held likewise.

## Operation
- States: IDLE, MUL. `in_ready = (state == IDLE)`.
- IDLE, transfer of non-MUL op: result/flags registered next edge, `out_valid` high that next cycle; stays IDLE (throughput 1/cycle).
- IDLE, transfer of MUL: latch A, B; clear accumulator; counter = 0; go MUL.
- MUL: each cycle, if B[counter] add A<<counter to accumulator (mod 2^WIDTH); counter++. On final bit (counter = WIDTH-1) write result, pulse `out_valid`, return IDLE.
- Arithmetic: ADD = A+B; SUB = A+~B+1; all mod 2^WIDTH.
- Logical ops are bitwise (not logical reduction).
- N = result[WIDTH-1]; Z = (result == 0).
- C: ADD carry-out; SUB carry-out of A+~B+1 (1 = no borrow, ARM convention); 0 for logic/MUL.
- V: ADD/SUB signed overflow = (A[msb] == B'[msb]) && (R[msb] != A[msb]), B' = B or ~B; 0 for logic/MUL.
- Reserved op: result 0, flags 4'b0100, `out_valid` after 1 cycle, same as simple op.
- `in_valid` while `in_ready` low: ignored (no transfer); upstream holds.
- No output backpressure; consumer must sample on `out_valid`.

## Timing
- Reset (`reset_n` low at edge): state IDLE, counter 0, `out_valid` 0, `alu_result` 0, `alu_flags` 0. Transfers during reset cycles are discarded.
- Reset mid-MUL: operation aborted, no `out_valid`, IDLE next cycle.
- Simple op latency: 1 cycle (accept edge k, `out_valid` in cycle k+1).
- MUL latency: WIDTH cycles after accept; `in_ready` low for cycles k+1..k+WIDTH-1, high in the cycle `out_valid` is high, so a back-to-back op may transfer that cycle.
- MUL with B = 0 still takes WIDTH cycles (no early exit).
- `alu_result`/`alu_flags` change only on `out_valid` cycles or reset.

## Structure
- Package `alu_pkg`: `alu_op_t` enum (3-bit codes above), `alu_state_t` enum {IDLE, MUL}, flag index constants `FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0`.
- Sub-module `alu_addsub #(WIDTH)`: combinational A ± B with carry-out and overflow; reused for the MUL accumulate step.
- Top holds FSM, counter (`$clog2(WIDTH)` bits), operand/accumulator registers, output registers.

## Test plan
- Reset: hold `reset_n` low 2 cycles with `in_valid`=1 → `out_valid`=0, result 0, flags 0000, `in_ready`=1 after release.
- ADD 0x7FFFFFFF + 1 → result 0x80000000, flags N=1 Z=0 C=0 V=1, `out_valid` 1 cycle after accept.
- SUB 5 − 5 → result 0, flags 0110; SUB 3 − 5 → 0xFFFFFFFE, flags 1000.
- Back-to-back AND 0xF0F0F0F0 & 0x0FF00FF0, ORR, EOR on consecutive cycles → 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00 on three consecutive `out_valid` cycles.
- MUL 0x0001_0003 × 0x0001_0005 → result 0x0008_000F, flags 0000, `out_valid` exactly 32 cycles after accept, `in_ready` low in between and `in_valid` ignored there.
- Reset asserted at cycle 10 of MUL → no `out_valid`, next ADD 2+2 returns 4 with normal 1-cycle latency; repeat ADD/SUB corners with `WIDTH`=8.
